// File: rtl/pipo_share_arbiter.sv
// Shared WIDTH-bit holding register written by two requesters through a
// round-robin req/gnt handshake, followed by a fixed hold window after each load.
module pipo_share_arbiter #(
  parameter int WIDTH       = 16,
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             src,
  output logic [CNT_W-1:0] load_cnt
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state_reg, state_next;
  logic [HW-1:0]    hold_cnt_reg, hold_cnt_next;
  logic             last_reg, last_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [1:0]       gnt_reg, gnt_next;
  logic             busy_reg, busy_next;
  logic             src_reg, src_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic [1:0] req_vec;
  logic [1:0] win;
  logic       grant;

  assign req_vec = {req1, req0};
  assign grant   = (state_reg == IDLE) && (|req_vec);

  // A requester wins if it is alone, or if the other one was served last.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_win
      assign win[gi] = req_vec[gi] & (~req_vec[1-gi] | (last_reg != 1'(gi)));
    end
  endgenerate

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_reg    <= IDLE;
      hold_cnt_reg <= '0;
      last_reg     <= 1'b1;
      q_reg        <= '0;
      gnt_reg      <= '0;
      busy_reg     <= 1'b0;
      src_reg      <= 1'b0;
      cnt_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
      last_reg     <= last_next;
      q_reg        <= q_next;
      gnt_reg      <= gnt_next;
      busy_reg     <= busy_next;
      src_reg      <= src_next;
      cnt_reg      <= cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (grant) begin
          state_next    = HOLD;
          hold_cnt_next = HW'(HOLD_CYCLES - 1);
        end
      end
      HOLD: begin
        if (hold_cnt_reg == '0) begin
          state_next = IDLE;
        end else begin
          hold_cnt_next = hold_cnt_reg - HW'(1);
        end
      end
      default: begin
        state_next    = IDLE;
        hold_cnt_next = '0;
      end
    endcase
  end

  always_comb begin
    q_next    = q_reg;
    gnt_next  = '0;
    busy_next = busy_reg;
    src_next  = src_reg;
    cnt_next  = cnt_reg;
    last_next = last_reg;
    if (grant) begin
      q_next    = win[1] ? data1 : data0;
      gnt_next  = win;
      busy_next = 1'b1;
      src_next  = win[1];
      cnt_next  = cnt_reg + CNT_W'(1);
      last_next = win[1];
    end else if ((state_reg == HOLD) && (hold_cnt_reg == '0)) begin
      busy_next = 1'b0;
    end
  end

  assign gnt0     = gnt_reg[0];
  assign gnt1     = gnt_reg[1];
  assign q        = q_reg;
  assign busy     = busy_reg;
  assign src      = src_reg;
  assign load_cnt = cnt_reg;

endmodule

// File: tb/tb_pipo_share_arbiter.sv
// Bench for pipo_share_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a countdown/queue-free model.
module tb_pipo_share_arbiter;

  localparam int WIDTH = 16;
  localparam int HOLD  = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b1;
  logic             clr = 1'b0;
  logic             req0 = 1'b0;
  logic             req1 = 1'b0;
  logic [WIDTH-1:0] data0 = '0;
  logic [WIDTH-1:0] data1 = '0;
  logic             gnt0, gnt1, busy, src;
  logic [WIDTH-1:0] q;
  logic [CNT_W-1:0] load_cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  pipo_share_arbiter #(.WIDTH(WIDTH), .HOLD_CYCLES(HOLD), .CNT_W(CNT_W)) dut (
    .clk(clk), .clr(clr),
    .req0(req0), .data0(data0), .req1(req1), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1), .q(q), .busy(busy), .src(src), .load_cnt(load_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Model: hold_left counts remaining busy cycles; a grant is only possible when it is 0.
  logic [WIDTH-1:0] m_q    = '0;
  logic             m_gnt0 = 1'b0;
  logic             m_gnt1 = 1'b0;
  logic             m_busy = 1'b0;
  logic             m_src  = 1'b0;
  logic [CNT_W-1:0] m_cnt  = '0;
  int               hold_left = 0;
  int               last_w    = 1;

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      m_q = '0; m_gnt0 = 0; m_gnt1 = 0; m_busy = 0; m_src = 0; m_cnt = '0;
      hold_left = 0; last_w = 1;
    end else if (hold_left > 0) begin
      m_gnt0 = 0; m_gnt1 = 0;
      hold_left = hold_left - 1;
      m_busy = (hold_left > 0);
    end else begin
      m_gnt0 = 0; m_gnt1 = 0;
      if (req0 || req1) begin
        int w;
        if (req0 && req1) w = 1 - last_w;
        else              w = req1 ? 1 : 0;
        last_w = w;
        m_q    = (w == 1) ? data1 : data0;
        m_gnt0 = (w == 0);
        m_gnt1 = (w == 1);
        m_src  = w[0];
        m_cnt  = m_cnt + 8'd1;
        hold_left = HOLD;
        m_busy = 1;
      end
    end
  end

  always @(negedge clk) begin
    checks++;
    if ({q, gnt0, gnt1, busy, src, load_cnt} !== {m_q, m_gnt0, m_gnt1, m_busy, m_src, m_cnt}) begin
      errors++;
      $display("FAIL cycle_cmp t=%0t got q=%h g0=%b g1=%b busy=%b src=%b cnt=%0d expected q=%h g0=%b g1=%b busy=%b src=%b cnt=%0d",
               $time, q, gnt0, gnt1, busy, src, load_cnt, m_q, m_gnt0, m_gnt1, m_busy, m_src, m_cnt);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic wait_any_gnt(output int who, output int at);
    who = -1;
    at  = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (gnt0 || gnt1) begin
        who = gnt1 ? 1 : 0;
        at  = cyc;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL gnt_timeout t=%0t got no grant expected a grant within 50 cycles", $time);
  endtask

  initial begin
    int who, at1, at2, at3, at4, seen, n;
    logic [WIDTH-1:0] last_d;

    // Reset with no requests
    #12;
    chk("rst_q", q, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gnt", {gnt0, gnt1}, 0);
    chk("rst_cnt", load_cnt, 0);
    #13 clr = 1'b1;
    @(negedge clk);
    chk("idle_cnt", load_cnt, 0);
    chk("idle_busy", busy, 0);

    // Single request
    req0 = 1'b1; data0 = 16'h0001;
    @(negedge clk);
    chk("single_q", q, 16'h0001);
    chk("single_gnt0", gnt0, 1);
    chk("single_src", src, 0);
    chk("single_cnt", load_cnt, 1);
    chk("single_busy", busy, 1);
    req0 = 1'b0;
    for (int i = 0; i < HOLD - 1; i++) begin
      @(negedge clk);
      chk("single_busy_hold", busy, 1);
      chk("single_gnt0_once", gnt0, 0);
    end
    @(negedge clk);
    chk("single_busy_end", busy, 0);

    // Reset pulse so requester 0 wins the next tie
    #2 clr = 1'b0;
    #1 chk("rst2_cnt", load_cnt, 0);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    chk("rst2_no_gnt", {gnt0, gnt1}, 0);

    // Simultaneous requests alternate with HOLD+1 spacing
    req0 = 1'b1; data0 = 16'h0007;
    req1 = 1'b1; data1 = 16'h00F0;
    wait_any_gnt(who, at1);
    chk("rr_first_who", who, 0);
    chk("rr_first_q", q, 16'h0007);
    wait_any_gnt(who, at2);
    chk("rr_second_who", who, 1);
    chk("rr_second_q", q, 16'h00F0);
    chk("rr_second_src", src, 1);
    chk("rr_spacing12", at2 - at1, HOLD + 1);
    wait_any_gnt(who, at3);
    chk("rr_third_who", who, 0);
    chk("rr_spacing23", at3 - at2, HOLD + 1);
    req0 = 1'b0; req1 = 1'b0;

    // Request raised in the second busy cycle waits for IDLE
    @(negedge clk);
    req1 = 1'b1; data1 = 16'hABCD;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("hold_q_kept", q, 16'h0007);
      chk("hold_no_gnt1", gnt1, 0);
    end
    @(negedge clk);
    chk("hold_busy_fell", busy, 0);
    chk("hold_q_still", q, 16'h0007);
    wait_any_gnt(who, at4);
    chk("hold_gnt_who", who, 1);
    chk("hold_gnt_q", q, 16'hABCD);
    chk("hold_gnt_spacing", at4 - at3, HOLD + 1);
    req1 = 1'b0;

    // Request dropped entirely inside HOLD
    req0 = 1'b1; data0 = 16'hBEEF;
    @(negedge clk);
    @(negedge clk);
    req0 = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (gnt0) seen = 1;
    end
    chk("drop_no_gnt0", seen, 0);
    chk("drop_q", q, 16'hABCD);
    chk("drop_cnt", load_cnt, 4);

    // Reset in the third busy cycle
    req0 = 1'b1; data0 = 16'h0005;
    wait_any_gnt(who, at1);
    req0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 clr = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_q", q, 0);
    chk("midrst_cnt", load_cnt, 0);
    chk("midrst_gnt", {gnt0, gnt1}, 0);
    @(negedge clk);
    #2 clr = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (gnt0 || gnt1) seen = 1;
    end
    chk("midrst_no_gnt", seen, 0);
    chk("midrst_cnt_after", load_cnt, 0);

    // Randomized traffic, occasional drops and async resets
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (gnt0 && ($urandom_range(1) == 0)) req0 = 1'b0;
      else if (gnt0) data0 = WIDTH'($urandom);
      if (gnt1 && ($urandom_range(1) == 0)) req1 = 1'b0;
      else if (gnt1) data1 = WIDTH'($urandom);
      if (!req0 && ($urandom_range(3) == 0)) begin req0 = 1'b1; data0 = WIDTH'($urandom); end
      if (!req1 && ($urandom_range(3) == 0)) begin req1 = 1'b1; data1 = WIDTH'($urandom); end
      if (req0 && ($urandom_range(15) == 0)) req0 = 1'b0;
      if (req1 && ($urandom_range(15) == 0)) req1 = 1'b0;
      if ($urandom_range(199) == 0) begin
        #2 clr = 1'b0;
        @(negedge clk);
        #2 clr = 1'b1;
      end
    end
    req0 = 1'b0; req1 = 1'b0;

    // 256 loads wrap the counter
    @(negedge clk);
    #2 clr = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    req0 = 1'b1; data0 = WIDTH'($urandom);
    n = 0;
    last_d = '0;
    while (n < 256) begin
      last_d = data0;
      wait_any_gnt(who, at1);
      if (who < 0) break;
      n++;
      if (n == 255) chk("wrap_cnt_255", load_cnt, 255);
      if (n < 256) data0 = WIDTH'($urandom);
    end
    req0 = 1'b0;
    chk("wrap_cnt_0", load_cnt, 0);
    chk("wrap_q", q, {16'h0, last_d});
    repeat (6) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipo_share_arbiter.md
Name: pipo_share_arbiter

Overview:
- Owns a WIDTH-bit parallel-in/parallel-out holding register and shares it between two requesters.
- Each requester writes through a req/gnt handshake. Arbitration is round-robin.
- After every load, a programmable hold window protects the register contents.
- Sits between two producer blocks and any consumer of the registered word (display, shifter, downstream PIPO chain).

Parameters:
- WIDTH, 16, data width of the shared register and both data inputs.
- HOLD_CYCLES, 4, number of cycles busy stays high after a load; minimum 1.
- CNT_W, 8, width of the load counter.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- clr  input  1  asynchronous, active-low reset (clr=0 resets immediately, independent of clk).
- req0  input  1  requester 0 write request; level, held until gnt0.
- data0  input  WIDTH  requester 0 write data; stable while req0=1.
- req1  input  1  requester 1 write request; level, held until gnt1.
- data1  input  WIDTH  requester 1 write data; stable while req1=1.
- gnt0  output  1  one-cycle pulse: data0 was loaded.
- gnt1  output  1  one-cycle pulse: data1 was loaded.
- q  output  WIDTH  shared register contents.
- busy  output  1  high during the hold window; no loads are accepted.
- src  output  1  index of the requester that performed the last load.
- load_cnt  output  CNT_W  number of loads since reset; wraps.

Behaviour:
- Reset (clr=0, asynchronous): q=0, gnt0=gnt1=0, busy=0, src=0, load_cnt=0, state=IDLE, hold counter=0. The round-robin pointer is set so that requester 0 wins the first tie.
- All outputs are registered. No combinational path exists from inputs to outputs.
- States: IDLE and HOLD.
- IDLE, at a rising edge with neither req high: stay in IDLE, outputs unchanged, gnt0=gnt1=0.
- IDLE, at a rising edge with exactly one req high: grant that requester.
- IDLE, at a rising edge with both req high: grant the requester not granted last (round-robin). After reset, requester 0 wins.
- Actions on a grant (same edge):
  - q <= selected data.
  - gnt_x <= 1 for exactly one cycle.
  - src <= x.
  - load_cnt <= load_cnt+1, modulo 2^CNT_W (255 -> 0).
  - busy <= 1, hold counter <= HOLD_CYCLES-1, state <= HOLD.
- HOLD, every edge:
  - gnt0=gnt1=0.
  - If the hold counter is 0: state <= IDLE, busy <= 0.
  - Otherwise the hold counter decrements.
  - Requests are not sampled. q is held.
- Timing:
  - gnt_x is high in the cycle after the sampling edge.
  - busy is high for exactly HOLD_CYCLES cycles.
  - Minimum spacing between consecutive grant edges is HOLD_CYCLES+1 cycles.
- A pending req that loses arbitration or arrives during HOLD stays pending. The requester keeps req high and is served at the next IDLE sample. No request is queued internally.
- If req drops before its gnt, the request is dropped silently and no load occurs.
- A requester that keeps req high after its gnt is treated as a new request at the next IDLE sample. It still obeys round-robin if the other requester is also requesting.
- Reset asserted mid-HOLD or coincident with a grant edge: reset wins; all outputs go to reset values immediately.
- Reset release: first grant is possible at the first rising edge after clr returns high.

Test Plan:
1. Reset: clr=0 at t=0, release after 25 ns with req0=req1=0 -> q=0, busy=0, gnt=0, load_cnt=0 during and after reset.
2. Single request: req0=1, data0=16'h0001 -> at the next edge q=16'h0001, gnt0 high 1 cycle, src=0, load_cnt=1, busy high 4 cycles. Then req0=0.
3. Simultaneous requests: req0=req1=1, data0=16'h0007, data1=16'h00F0, both held ->
   - First grant gnt0, q=16'h0007.
   - Second grant gnt1 exactly 5 cycles later, q=16'h00F0, src=1.
   - Third grant gnt0 again; the grants strictly alternate.
4. Request during HOLD: req1 raised in the second busy cycle -> no load until busy falls. gnt1 then occurs at the first IDLE edge; q is unchanged in the meantime.
5. Dropped request: req0 high for 2 cycles entirely inside HOLD, then low -> no gnt0, q and load_cnt unchanged.
6. Reset mid-operation and wrap:
   - clr=0 in the third busy cycle -> busy=0, q=0, load_cnt=0 immediately, no gnt after release without a req.
   - 256 single loads -> load_cnt wraps to 0.
